mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one unified, variable-latency memory port between the core's instruction fetch (instrreq/instradr) and data access (datareq/dataadr/memwrite).
- Drives instrabort/dataabort back to the core as stall signals; dataabort also gates the core clock.
- Sits between the mips core and the external memory model/controller.

Parameters:
- N, 64, data and data-address width.
- FAIR_LIMIT, 4, consecutive data grants before instruction priority is forced (used only with ARB_FAIR_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- instrreq  in  1  core requests instruction fetch
- instradr  in  32  fetch address
- instr  out  32  fetched instruction (registered)
- instrabort  out  1  fetch not yet satisfied; core holds fetch
- datareq  in  1  core requests data access
- dataadr  in  N  data address
- writedata  in  N  store data
- memwrite  in  2  store byte-enable code; 00 means read
- readdata  out  N  load data (registered)
- dataabort  out  1  data access not yet satisfied; core clock frozen
- mem_req  out  1  memory request (registered)
- mem_we  out  2  memory write code, copy of latched memwrite
- mem_adr  out  N  memory address; instradr zero-extended for fetches
- mem_wdata  out  N  memory store data
- mem_rdata  in  N  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes current access this cycle

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, mem_req=0, mem_we=00, mem_adr=0, mem_wdata=0, instr=0, readdata=0, fair count=0.
- Aborts are combinational:
  - dataabort = datareq & (state != DRESP)
  - instrabort = instrreq & (state != IRESP)
  - Both therefore equal their request lines during reset.
- FSM states: IDLE, DSRV, ISRV, DRESP, IRESP.
- IDLE:
  - datareq wins over instrreq (base priority). Go to DSRV or ISRV.
  - On entry, latch adr/we/wdata into the mem_* registers and set mem_req=1 in the next cycle.
- DSRV/ISRV:
  - Hold mem_req and all mem_* outputs stable until mem_ready.
  - On mem_ready: capture mem_rdata into readdata (DSRV, reads only) or instr (ISRV). Clear mem_req. Go to DRESP/IRESP.
  - Stores leave readdata unchanged.
- DRESP/IRESP:
  - Exactly one cycle. Matching abort is low, so the core samples registered data at the next edge. Return to IDLE.
  - A request still high in the following IDLE cycle is treated as a new access.
- Latency: request seen in IDLE at cycle 0 → mem_req high from cycle 1 → mem_ready at cycle k → abort low in cycle k+1. Minimum 3 cycles (k=1).
- Simultaneous requests: data served first, instruction next. The instruction request's abort stays high throughout.
- mem_ready outside DSRV/ISRV is ignored.
- Request drop while in DSRV/ISRV: the access still completes. The RESP cycle is spent with abort low, harmlessly.
- Reset mid-access: immediate return to IDLE. mem_req drops asynchronously and the in-flight access is abandoned.
- Address width: instradr is zero-extended to N bits; upper mem_adr bits are 0 for fetches.

Optional Feature:
- Macro ARB_FAIR_EN.
- Defined:
  - Counter of consecutive data grants, saturating at FAIR_LIMIT.
  - Reset on any instruction grant, or on an IDLE cycle with no requests.
  - When count==FAIR_LIMIT and both requests are present in IDLE, the instruction is granted.
- Undefined: strict data priority, no counter logic.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, DSRV, ISRV, DRESP, IRESP}
  - memwrite code constants (MW_NONE=2'b00)
  - default FAIR_LIMIT
- Sub-module arb_fair_cnt: saturating grant counter with clear/inc/sat outputs, instantiated only under ARB_FAIR_EN.
- FSM and datapath registers stay in the top module.

Test Plan:
- Data read, instrreq=0, dataadr=0x40, memory returns 0x1122334455667788 with k=2:
  - mem_req high cycles 1–2, mem_adr=0x40, mem_we=00.
  - dataabort low only in cycle 3, readdata=0x1122334455667788.
- Fetch, instradr=0x0000_0100, mem_rdata=0x20080005, k=1:
  - mem_adr=0x100 (upper bits 0).
  - instrabort low cycle 2, instr=0x20080005.
- Simultaneous datareq (store, memwrite=11, writedata=0xDEAD) and instrreq:
  - Data access first with mem_we=11, mem_wdata=0xDEAD; readdata unchanged.
  - Then fetch; instrabort stays high until IRESP.
- reset asserted in DSRV (cycle 2 of a 5-cycle access):
  - mem_req=0 immediately, state IDLE, readdata=0.
  - After release, new access restarts from cycle 0.
- Stall: mem_ready held low 20 cycles → mem_req/mem_adr stable all 20 cycles, dataabort high throughout.
- With ARB_FAIR_EN, FAIR_LIMIT=4, datareq and instrreq held high:
  - Grant order D,D,D,D,I,D…
  - Without the macro: D grants only while datareq stays high.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DSRV,
    ISRV,
    DRESP,
    IRESP
  } arb_state_t;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;

  localparam int unsigned FAIR_LIMIT_DEF = 4;

  function automatic logic is_store(input logic [1:0] mw);
    return mw != MW_NONE;
  endfunction

endpackage

// File: rtl/arb_fair_cnt.sv
// Saturating count of consecutive data grants; sat tells the arbiter to let a
// waiting fetch through. Used by mem_port_arbiter when ARB_FAIR_EN is defined.
module arb_fair_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = FAIR_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_sat
);

  localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  assign o_sat = (r_cnt == CW'(LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates core instruction fetch and data access onto one variable-latency
// memory port. Optional fetch-fairness counter enabled by macro ARB_FAIR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N          = 64,
  parameter int unsigned FAIR_LIMIT = FAIR_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instrreq,
  input  logic [31:0]   instradr,
  output logic [31:0]   instr,
  output logic          instrabort,
  input  logic          datareq,
  input  logic [N-1:0]  dataadr,
  input  logic [N-1:0]  writedata,
  input  logic [1:0]    memwrite,
  output logic [N-1:0]  readdata,
  output logic          dataabort,
  output logic          mem_req,
  output logic [1:0]    mem_we,
  output logic [N-1:0]  mem_adr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata,
  input  logic          mem_ready
);

  arb_state_t   r_state;
  logic         r_mem_req;
  logic [1:0]   r_mem_we;
  logic [N-1:0] r_mem_adr;
  logic [N-1:0] r_mem_wdata;
  logic [N-1:0] r_readdata;
  logic [31:0]  r_instr;

  logic w_grant_d;
  logic w_grant_i;
  logic w_fair_force;

`ifdef ARB_FAIR_EN
  logic w_fair_sat;
  logic w_fair_clr;
  logic w_fair_inc;

  assign w_fair_inc = (r_state == IDLE) && w_grant_d;
  assign w_fair_clr = (r_state == IDLE) && (w_grant_i || (!datareq && !instrreq));

  arb_fair_cnt #(.LIMIT(FAIR_LIMIT)) u_fair_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_fair_clr),
    .i_inc (w_fair_inc),
    .o_sat (w_fair_sat)
  );

  assign w_fair_force = w_fair_sat && instrreq;
`else
  assign w_fair_force = 1'b0;
`endif

  assign w_grant_d = datareq && !w_fair_force;
  assign w_grant_i = instrreq && !w_grant_d;

  // Aborts stay combinational so the core is released in the RESP cycle itself.
  assign dataabort  = datareq  && (r_state != DRESP);
  assign instrabort = instrreq && (r_state != IRESP);

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_adr   = r_mem_adr;
  assign mem_wdata = r_mem_wdata;
  assign readdata  = r_readdata;
  assign instr     = r_instr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= MW_NONE;
      r_mem_adr   <= '0;
      r_mem_wdata <= '0;
      r_readdata  <= '0;
      r_instr     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state     <= DSRV;
            r_mem_req   <= 1'b1;
            r_mem_we    <= memwrite;
            r_mem_adr   <= dataadr;
            r_mem_wdata <= writedata;
          end else if (w_grant_i) begin
            r_state   <= ISRV;
            r_mem_req <= 1'b1;
            r_mem_we  <= MW_NONE;
            r_mem_adr <= N'(instradr);
          end
        end
        DSRV: begin
          if (mem_ready) begin
            if (!is_store(r_mem_we)) begin
              r_readdata <= mem_rdata;
            end
            r_mem_req <= 1'b0;
            r_state   <= DRESP;
          end
        end
        ISRV: begin
          if (mem_ready) begin
            r_instr   <= mem_rdata[31:0];
            r_mem_req <= 1'b0;
            r_state   <= IRESP;
          end
        end
        DRESP:   r_state <= IDLE;
        IRESP:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
